change_dispenser: RTL and testbench
===================================

CHANGE_DISPENSER -- requirements
Module: change_dispenser

Interface
REQ-001 The block SHALL have parameter TUBE_MAX, default 15: capacity of each coin tube and the count loaded on reset or refill.
REQ-002 The block SHALL have parameter ACK_TIMEOUT, default 255: maximum cycles an ejection request waits for mech_ack.
REQ-003 Clk  input  1  single clock; all state updates on the rising edge.
REQ-004 rst_n  input  1  synchronous, active-low reset.
REQ-005 vend  input  1  level vend-complete indicator from the vending FSM; only its rising edge starts a payout.
REQ-006 amt  input  9  change owed in cents; sampled on the cycle the vend rising edge is detected.
REQ-007 mech_ack  input  1  coin mechanism acknowledge; high means the requested coin has been ejected.
REQ-008 refill  input  1  tube refill request.
REQ-009 eject_d  output  1  dime ejection request.
REQ-010 eject_n  output  1  nickel ejection request.
REQ-011 busy  output  1  high from payout start until DONE or FAULT.
REQ-012 done  output  1  one-cycle pulse marking a completed payout.
REQ-013 fault  output  1  sticky payout failure flag.
REQ-014 dimes_left  output  4  current dime tube count.
REQ-015 nickels_left  output  4  current nickel tube count.

Function
REQ-016 The block SHALL register vend into vend_q and detect a start as vend=1 & vend_q=0, acted on only in IDLE; starts in any other state SHALL be ignored.
REQ-017 The FSM SHALL have states IDLE, SEL, EJ_D, EJ_N, GAP, DONE and FAULT, all outputs registered.
REQ-018 On a detected start in IDLE, the FSM SHALL load rem <= amt (9-bit) and go to SEL on the next edge, with busy=1 from that cycle.
REQ-019 In SEL, a greedy choice SHALL apply in priority order:
- rem>=10 & dimes_left>0 -> EJ_D
- rem>=5 & nickels_left>0 -> EJ_N
- rem==0 -> DONE
- otherwise -> FAULT
REQ-020 In EJ_D / EJ_N, eject_d / eject_n respectively SHALL be held high, exactly one of them at a time, until mech_ack is sampled high.
REQ-021 On that ack edge:
- the eject output SHALL drop
- rem SHALL decrease by 10 or 5
- the matching tube count SHALL decrement by 1
- the FSM SHALL go to GAP
REQ-022 GAP SHALL hold both eject outputs low until mech_ack is sampled low, then go to SEL; mech_ack high in any other state SHALL be ignored.
REQ-023 A timeout counter SHALL clear on entry to EJ_D, EJ_N or GAP; if ACK_TIMEOUT cycles pass in that state without the awaited mech_ack level, the FSM SHALL go to FAULT.
REQ-024 DONE SHALL last one cycle with done=1 and busy=0, then return to IDLE.
REQ-025 FAULT SHALL hold fault=1, busy=0 and both eject outputs low, and SHALL be left only via rst_n.
REQ-026 refill SHALL set both tube counts to TUBE_MAX on the next edge only in IDLE; refill in other states SHALL be ignored.
REQ-027 Tube counts SHALL never underflow (guaranteed by the SEL checks) and SHALL never exceed TUBE_MAX.
REQ-028 amt not a multiple of 5 SHALL pay greedily and then end in FAULT with rem<5 and rem!=0.
REQ-029 Minimum payout latency SHALL be: start edge -> SEL +1 cycle -> eject asserted +1 cycle.

Reset
REQ-030 With rst_n low at an edge, the block SHALL set state=IDLE, rem=0, vend_q=0, timeout counter=0, eject_d=0, eject_n=0, busy=0, done=0, fault=0, dimes_left=TUBE_MAX and nickels_left=TUBE_MAX.
REQ-031 Reset SHALL take priority over every other input, including during ejection; a request in flight SHALL be abandoned with no count decrement.

Verification
REQ-032 amt=20, vend 0->1, mech_ack pulses 1 cycle after each request -> two eject_d handshakes, no eject_n, done pulse, dimes_left=13.
REQ-033 amt=15 -> one eject_d then one eject_n, done; dimes_left=14, nickels_left=14.
REQ-034 dimes_left drained to 0, then amt=10 -> two eject_n handshakes, done, nickels_left decremented by 2.
REQ-035 amt=7 -> one eject_n, then FAULT with fault=1 held and rem=2; a later vend edge produces no response until rst_n.
REQ-036 amt=10 with mech_ack held low -> eject_d high for ACK_TIMEOUT cycles, then FAULT with eject_d=0 and dimes_left unchanged.
REQ-037 rst_n low while eject_n=1 -> next edge all outputs at reset values; refill pulsed during busy -> counts unchanged.

Source files
------------

// File: rtl/change_dispenser_if.sv
// Bus between the vending controller, the coin mechanism and the change dispenser.
//   vend, amt      : payout request (level vend, change owed in cents)
//   mech_ack       : coin mechanism acknowledge
//   refill         : tube refill request
//   eject_d/_n     : dime / nickel ejection requests
//   busy/done/fault: payout status
//   dimes_left, nickels_left : tube counts
interface change_dispenser_if;
  logic       vend;
  logic [8:0] amt;
  logic       mech_ack;
  logic       refill;
  logic       eject_d;
  logic       eject_n;
  logic       busy;
  logic       done;
  logic       fault;
  logic [3:0] dimes_left;
  logic [3:0] nickels_left;

  modport master (
    output vend, amt, mech_ack, refill,
    input  eject_d, eject_n, busy, done, fault, dimes_left, nickels_left
  );

  modport slave (
    input  vend, amt, mech_ack, refill,
    output eject_d, eject_n, busy, done, fault, dimes_left, nickels_left
  );
endinterface

// File: rtl/change_dispenser.sv
// Greedy dime/nickel change dispenser with coin-mechanism handshake.
// Ports:
//   Clk   : single clock, rising edge
//   rst_n : synchronous active-low reset
//   bus   : change_dispenser_if.slave (request, mechanism handshake, status, tube counts)
// A rising edge of vend in IDLE latches amt and pays it out, dimes first,
// one coin per eject/ack/gap handshake. Running out of coins or an
// unreachable remainder ends in a sticky FAULT that only rst_n clears.
module change_dispenser #(
  parameter int unsigned TUBE_MAX    = 15,
  parameter int unsigned ACK_TIMEOUT = 255
) (
  input logic              Clk,
  input logic              rst_n,
  change_dispenser_if.slave bus
);

  localparam int unsigned AMT_W = 9;
  localparam int unsigned CNT_W = 4;
  localparam int unsigned TMO_W = (ACK_TIMEOUT > 1) ? $clog2(ACK_TIMEOUT) : 1;

  localparam logic [CNT_W-1:0] FULL     = CNT_W'(TUBE_MAX);
  localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(ACK_TIMEOUT - 1);
  localparam logic [AMT_W-1:0] DIME     = AMT_W'(10);
  localparam logic [AMT_W-1:0] NICKEL   = AMT_W'(5);

  typedef enum logic [2:0] {
    S_IDLE,
    S_SEL,
    S_EJ_D,
    S_EJ_N,
    S_GAP,
    S_DONE,
    S_FAULT
  } state_t;

  state_t             state_q, state_d;
  logic [AMT_W-1:0]   rem_q, rem_d;
  logic [TMO_W-1:0]   tmo_q, tmo_d;
  logic [CNT_W-1:0]   dimes_q, dimes_d;
  logic [CNT_W-1:0]   nickels_q, nickels_d;
  logic               vend_q;
  logic               eject_d_q, eject_n_q, busy_q, done_q, fault_q;
  logic               eject_d_d, eject_n_d, busy_d, done_d, fault_d;
  logic               start_c;
  logic               tmo_hit_c;
  logic               waiting_c;

  assign start_c   = bus.vend & ~vend_q;
  assign tmo_hit_c = (tmo_q == TMO_LAST);

  // Next-state, datapath and registered-output decode
  always_comb begin
    state_d   = state_q;
    rem_d     = rem_q;
    dimes_d   = dimes_q;
    nickels_d = nickels_q;

    case (state_q)
      S_IDLE: begin
        if (bus.refill) begin
          dimes_d   = FULL;
          nickels_d = FULL;
        end
        if (start_c) begin
          rem_d   = bus.amt;
          state_d = S_SEL;
        end
      end
      S_SEL: begin
        if (rem_q >= DIME && dimes_q != '0)        state_d = S_EJ_D;
        else if (rem_q >= NICKEL && nickels_q != '0) state_d = S_EJ_N;
        else if (rem_q == '0)                      state_d = S_DONE;
        else                                       state_d = S_FAULT;
      end
      S_EJ_D: begin
        if (bus.mech_ack) begin
          rem_d   = rem_q - DIME;
          dimes_d = dimes_q - CNT_W'(1);
          state_d = S_GAP;
        end else if (tmo_hit_c) begin
          state_d = S_FAULT;
        end
      end
      S_EJ_N: begin
        if (bus.mech_ack) begin
          rem_d     = rem_q - NICKEL;
          nickels_d = nickels_q - CNT_W'(1);
          state_d   = S_GAP;
        end else if (tmo_hit_c) begin
          state_d = S_FAULT;
        end
      end
      S_GAP: begin
        if (!bus.mech_ack)  state_d = S_SEL;
        else if (tmo_hit_c) state_d = S_FAULT;
      end
      S_DONE:  state_d = S_IDLE;
      S_FAULT: state_d = S_FAULT;
      default: state_d = S_IDLE;
    endcase

    // Counter restarts whenever a wait state is (re)entered
    waiting_c = (state_d == S_EJ_D) || (state_d == S_EJ_N) || (state_d == S_GAP);
    tmo_d     = (waiting_c && state_d == state_q) ? tmo_q + TMO_W'(1) : '0;

    // Outputs are a registered decode of the next state
    eject_d_d = (state_d == S_EJ_D);
    eject_n_d = (state_d == S_EJ_N);
    busy_d    = (state_d == S_SEL) || waiting_c;
    done_d    = (state_d == S_DONE);
    fault_d   = (state_d == S_FAULT);
  end

  // State and output registers
  always_ff @(posedge Clk) begin
    if (!rst_n) begin
      state_q   <= S_IDLE;
      rem_q     <= '0;
      vend_q    <= 1'b0;
      tmo_q     <= '0;
      dimes_q   <= FULL;
      nickels_q <= FULL;
      eject_d_q <= 1'b0;
      eject_n_q <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      fault_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      rem_q     <= rem_d;
      vend_q    <= bus.vend;
      tmo_q     <= tmo_d;
      dimes_q   <= dimes_d;
      nickels_q <= nickels_d;
      eject_d_q <= eject_d_d;
      eject_n_q <= eject_n_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      fault_q   <= fault_d;
    end
  end

  assign bus.eject_d      = eject_d_q;
  assign bus.eject_n      = eject_n_q;
  assign bus.busy         = busy_q;
  assign bus.done         = done_q;
  assign bus.fault        = fault_q;
  assign bus.dimes_left   = dimes_q;
  assign bus.nickels_left = nickels_q;

endmodule

// File: tb/tb_change_dispenser.sv
// Self-checking bench for change_dispenser: directed table, corner sequences,
// and randomized payouts against an arithmetic greedy-change model.
module tb_change_dispenser;

  localparam int TMAX = 15;
  localparam int TMO  = 255;

  logic Clk;
  logic rst_n;
  int   n_cmp;
  int   n_fail;

  change_dispenser_if bus();

  change_dispenser #(.TUBE_MAX(TMAX), .ACK_TIMEOUT(TMO)) dut (
    .Clk  (Clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  typedef struct {
    bit rst;
    int amt;
    int nd;
    int nn;
    bit dn;
    bit ft;
    int dl;
    int nl;
  } vec_t;

  vec_t vt[9];

  task automatic chk(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic do_reset();
    bus.vend     = 1'b0;
    bus.amt      = '0;
    bus.mech_ack = 1'b0;
    bus.refill   = 1'b0;
    rst_n        = 1'b0;
    @(negedge Clk);
    rst_n = 1'b1;
  endtask

  // Raises vend and behaves as the coin mechanism until done or fault.
  task automatic run_payout(input int a, input int dly, input int gap, input bit refill_busy,
                            output int nd, output int nn, output bit gd, output bit gf,
                            output bit both, output bit to);
    int wc;
    int gc;
    nd = 0; nn = 0; gd = 0; gf = 0; both = 0; to = 0; wc = 0; gc = 0;
    bus.amt  = 9'(a);
    bus.vend = 1'b1;
    for (int cyc = 0; cyc < 3000 && !gd && !gf; cyc++) begin
      @(negedge Clk);
      if (bus.eject_d && bus.eject_n) both = 1;
      if (bus.done)  gd = 1;
      if (bus.fault) gf = 1;
      if (refill_busy) bus.refill = bus.busy;
      if ((bus.eject_d || bus.eject_n) && !bus.mech_ack) begin
        if (wc >= dly) begin
          bus.mech_ack = 1'b1;
          if (bus.eject_d) nd++; else nn++;
          wc = 0;
        end else wc++;
      end else if (bus.mech_ack && !bus.eject_d && !bus.eject_n) begin
        if (gc >= gap) begin
          bus.mech_ack = 1'b0;
          gc = 0;
        end else gc++;
      end
    end
    if (!gd && !gf) to = 1;
    bus.vend     = 1'b0;
    bus.mech_ack = 1'b0;
    bus.refill   = 1'b0;
    @(negedge Clk);
  endtask

  initial begin
    int nd, nn, cnt;
    bit gd, gf, both, to, quiet;
    int md, mn, a, e_nd, e_nn, r;
    bit e_ok;

    n_cmp = 0;
    n_fail = 0;
    rst_n = 1'b0;
    bus.vend = 1'b0; bus.amt = '0; bus.mech_ack = 1'b0; bus.refill = 1'b0;
    @(negedge Clk);
    @(negedge Clk);
    rst_n = 1'b1;

    // Reset state
    chk("rst_eject_d", bus.eject_d, 0);
    chk("rst_eject_n", bus.eject_n, 0);
    chk("rst_busy", bus.busy, 0);
    chk("rst_done", bus.done, 0);
    chk("rst_fault", bus.fault, 0);
    chk("rst_dimes", bus.dimes_left, TMAX);
    chk("rst_nickels", bus.nickels_left, TMAX);

    // Minimum latency: start edge -> SEL (busy) -> eject
    bus.amt = 9'd10; bus.vend = 1'b1;
    @(negedge Clk);
    chk("lat_busy", bus.busy, 1);
    chk("lat_no_eject_in_sel", bus.eject_d, 0);
    @(negedge Clk);
    chk("lat_eject_d", bus.eject_d, 1);
    do_reset();

    // Directed table (tube counts carry over unless rst is set)
    vt[0] = '{1, 20,  2,  0, 1, 0, 13, 15};
    vt[1] = '{1, 15,  1,  1, 1, 0, 14, 14};
    vt[2] = '{0,  0,  0,  0, 1, 0, 14, 14};
    vt[3] = '{0, 45,  4,  1, 1, 0, 10, 13};
    vt[4] = '{1,  7,  0,  1, 0, 1, 15, 14};
    vt[5] = '{1, 200, 15, 10, 1, 0,  0,  5};
    vt[6] = '{0, 10,  0,  2, 1, 0,  0,  3};
    vt[7] = '{0, 20,  0,  3, 0, 1,  0,  0};
    vt[8] = '{1, 511, 15, 15, 0, 1,  0,  0};
    for (int i = 0; i < 9; i++) begin
      if (vt[i].rst) do_reset();
      run_payout(vt[i].amt, 1, 0, 0, nd, nn, gd, gf, both, to);
      chk($sformatf("vec%0d_dimes_paid", i), nd, vt[i].nd);
      chk($sformatf("vec%0d_nickels_paid", i), nn, vt[i].nn);
      chk($sformatf("vec%0d_done", i), gd, vt[i].dn);
      chk($sformatf("vec%0d_fault", i), gf, vt[i].ft);
      chk($sformatf("vec%0d_dimes_left", i), bus.dimes_left, vt[i].dl);
      chk($sformatf("vec%0d_nickels_left", i), bus.nickels_left, vt[i].nl);
      chk($sformatf("vec%0d_onehot", i), both, 0);
    end

    // Odd amount: sticky fault with rem 2, later vend edges ignored
    do_reset();
    run_payout(7, 1, 1, 0, nd, nn, gd, gf, both, to);
    chk("odd_nickels_paid", nn, 1);
    chk("odd_fault", gf, 1);
    chk("odd_rem", int'(dut.rem_q), 2);
    bus.vend = 1'b1;
    quiet = 1;
    for (int k = 0; k < 8; k++) begin
      @(negedge Clk);
      if (bus.busy || bus.eject_d || bus.eject_n || !bus.fault) quiet = 0;
    end
    bus.vend = 1'b0;
    chk("fault_sticky_ignores_vend", quiet, 1);
    do_reset();
    chk("fault_cleared_by_reset", bus.fault, 0);

    // Ack never arrives: eject_d held ACK_TIMEOUT cycles then FAULT
    bus.amt = 9'd10; bus.vend = 1'b1;
    cnt = 0;
    for (int k = 0; k < 400 && !bus.fault; k++) begin
      @(negedge Clk);
      if (bus.eject_d) cnt++;
    end
    chk("tmo_eject_cycles", cnt, TMO);
    chk("tmo_fault", bus.fault, 1);
    chk("tmo_eject_low", bus.eject_d, 0);
    chk("tmo_busy_low", bus.busy, 0);
    chk("tmo_dimes_unchanged", bus.dimes_left, TMAX);

    // Reset while a nickel request is in flight
    do_reset();
    run_payout(5, 0, 0, 0, nd, nn, gd, gf, both, to);
    bus.amt = 9'd5; bus.vend = 1'b1;
    for (int k = 0; k < 10 && !bus.eject_n; k++) @(negedge Clk);
    chk("midrst_eject_n_seen", bus.eject_n, 1);
    bus.vend = 1'b0;
    rst_n = 1'b0;
    @(negedge Clk);
    rst_n = 1'b1;
    chk("midrst_eject_n", bus.eject_n, 0);
    chk("midrst_busy", bus.busy, 0);
    chk("midrst_fault", bus.fault, 0);
    chk("midrst_done", bus.done, 0);
    chk("midrst_nickels", bus.nickels_left, TMAX);

    // Refill ignored while busy, honoured in IDLE
    run_payout(20, 1, 0, 0, nd, nn, gd, gf, both, to);
    run_payout(10, 2, 1, 1, nd, nn, gd, gf, both, to);
    chk("refill_busy_done", gd, 1);
    chk("refill_busy_dimes", bus.dimes_left, 12);
    chk("refill_busy_nickels", bus.nickels_left, TMAX);
    bus.refill = 1'b1;
    @(negedge Clk);
    bus.refill = 1'b0;
    chk("refill_idle_dimes", bus.dimes_left, TMAX);
    chk("refill_idle_nickels", bus.nickels_left, TMAX);

    // Randomized payouts against the greedy arithmetic model
    do_reset();
    md = TMAX; mn = TMAX;
    for (int it = 0; it < 40; it++) begin
      if ($urandom_range(0, 3) == 0) begin
        bus.refill = 1'b1;
        @(negedge Clk);
        bus.refill = 1'b0;
        md = TMAX; mn = TMAX;
      end
      if ($urandom_range(0, 3) == 0) a = int'($urandom_range(0, 120));
      else a = 5 * int'($urandom_range(0, 24));
      e_nd = (a / 10 < md) ? a / 10 : md;
      r    = a - 10 * e_nd;
      e_nn = (r / 5 < mn) ? r / 5 : mn;
      r    = r - 5 * e_nn;
      e_ok = (r == 0);
      run_payout(a, int'($urandom_range(0, 3)), int'($urandom_range(0, 2)), 0,
                 nd, nn, gd, gf, both, to);
      md = md - e_nd;
      mn = mn - e_nn;
      chk($sformatf("rnd%0d_a%0d_dimes_paid", it, a), nd, e_nd);
      chk($sformatf("rnd%0d_a%0d_nickels_paid", it, a), nn, e_nn);
      chk($sformatf("rnd%0d_a%0d_done", it, a), gd, e_ok);
      chk($sformatf("rnd%0d_a%0d_fault", it, a), gf, !e_ok);
      chk($sformatf("rnd%0d_dimes_left", it), bus.dimes_left, md);
      chk($sformatf("rnd%0d_nickels_left", it), bus.nickels_left, mn);
      chk($sformatf("rnd%0d_onehot", it), both, 0);
      chk($sformatf("rnd%0d_no_hang", it), to, 0);
      if (gf || to) begin
        do_reset();
        md = TMAX; mn = TMAX;
      end
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
